divider: RTL
============

Name: divider

Overview:
- IEEE-754 single-precision divider, z = a / b. It is the inverse-operation companion to the floating-point multiplier and sits beside it in the arithmetic library.
- Operands and result move over the team's standard stb/ack handshake: a first, then b, then z.
- Iterative restoring mantissa division, one quotient bit per cycle, followed by normalise, round and pack stages.

Parameters:
- None. Single precision is fixed and the number of division steps is fixed at 27.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- input_a  input  32  dividend (IEEE-754 single)
- input_a_stb  input  1  dividend valid
- input_a_ack  output  1  dividend accepted
- input_b  input  32  divisor (IEEE-754 single)
- input_b_stb  input  1  divisor valid
- input_b_ack  output  1  divisor accepted
- output_z  output  32  quotient (IEEE-754 single)
- output_z_stb  output  1  quotient valid
- output_z_ack  input  1  quotient consumed

Behaviour:
- Reset:
  - rst asserted at any time, including mid-division, forces state=get_a and input_a_ack=input_b_ack=output_z_stb=0 immediately (asynchronous).
  - output_z resets to 0.
  - An operation in flight is discarded.
- Handshake:
  - A transfer occurs on a clock edge where ack/stb and its partner are both high.
  - The block raises input_a_ack in get_a. After the a transfer it drops the ack and moves to get_b, which follows the same rule.
  - In put_z the block registers output_z and raises output_z_stb. output_z holds stable while stb is high.
  - On the transfer edge (stb && output_z_ack) stb drops and state returns to get_a.
  - Upstream stb held with no ack, or downstream ack with no stb, has no effect.
- States, in order: get_a, get_b, unpack, special_cases, normalise_a, normalise_b, divide_0, divide_1, divide_2, normalise_1, normalise_2, round, pack, put_z.
- unpack:
  - m = frac[22:0].
  - e = exp - 127, 10-bit signed.
  - s = bit 31.
- special_cases, checked in priority order; each case goes straight to put_z:
  - a or b NaN -> 0xFFC00000.
  - a inf and b inf -> 0xFFC00000.
  - a inf -> inf, sign a_s^b_s.
  - b inf -> signed zero.
  - b zero: if a is also zero -> 0xFFC00000, else signed inf.
  - a zero -> signed zero.
  - Otherwise, per operand: a denormal gets e = -126, a normal gets hidden bit m[23]=1.
- normalise_a / normalise_b: shift m left and decrement e, one bit per cycle, until m[23]=1.
- divide_0:
  - z_s = a_s^b_s.
  - z_e = a_e - b_e.
  - dividend = {a_m, 26'b0}; divisor = b_m; quotient = 0; remainder = 0; count = 0.
- divide_1, 27 cycles, one per quotient bit, MSB first:
  - Restoring step: shift in the next dividend bit, subtract divisor if remainder >= divisor, set the quotient LSB.
  - Result: Q = floor(a_m*2^26/b_m), with 2^25 < Q < 2^27.
- divide_2:
  - z_m = Q[26:3], guard = Q[2], round_bit = Q[1].
  - sticky = Q[0] | (remainder != 0).
- normalise_1: while z_m[23]=0, shift left, shifting guard into z_m[0]; guard <= round_bit; round_bit <= 0; z_e--.
- normalise_2:
  - While z_e < -126: shift right; guard <= z_m[0]; round_bit <= guard; sticky |= round_bit; z_e++.
  - This produces a denormal, or zero when the value is fully shifted out.
- round:
  - Round to nearest even: if guard && (round_bit|sticky|z_m[0]) then z_m++.
  - If z_m was 0xFFFFFF, z_e++.
- pack:
  - exp = z_e+127, frac = z_m[22:0].
  - exp = 0 if z_e == -126 and z_m[23] == 0.
  - z_e > 127 -> signed inf.
- Latency: with normal operands and no normalise shifts, output_z_stb is high from the 39th edge after the b transfer edge. Each extra normalise shift adds 1 cycle.
- Throughput: one operation in flight; a new a is not acked until z has been consumed.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2), ack held high -> output_z = 0x40400000; stb first high on the 39th edge after the b transfer.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB. This checks round-up and sticky.
- Specials:
  - 1/0 (0x3F800000, 0x00000000) -> 0x7F800000.
  - 0/0 -> 0xFFC00000.
  - inf/inf -> 0xFFC00000.
  - 0xBF800000 / 0x7F800000 -> 0x80000000.
  - NaN/2 -> 0xFFC00000.
- Range limits:
  - 0x7F7FFFFF / 0x3F000000 -> 0x7F800000 (overflow).
  - 0x00800000 / 0x40000000 -> 0x00400000 (denormal result).
  - 0x00000001 / 0x3F000000 -> 0x00000002 (denormal input).
- Backpressure: hold output_z_ack low for 20 cycles in put_z -> output_z stable, stb high, input_a_ack low. Ack once -> stb drops next edge, input_a_ack rises.
- Reset: assert rst during divide_1 -> all acks/stb are 0 immediately. Release rst, then issue 0x41200000 / 0x40A00000 -> 0x40000000.

Source files
------------

// File: rtl/divider.sv
// IEEE-754 single-precision divider, z = a / b.
// Restoring mantissa division (one quotient bit per cycle) followed by
// normalise, round-to-nearest-even and pack stages. One operation in flight.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   input_a        dividend (IEEE-754 single), accepted on input_a_stb && input_a_ack
//   input_b        divisor  (IEEE-754 single), accepted on input_b_stb && input_b_ack
//   output_z       quotient, valid while output_z_stb, consumed on output_z_ack
module divider (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL_CASES, NORMALISE_A, NORMALISE_B,
    DIVIDE_0, DIVIDE_1, DIVIDE_2, NORMALISE_1, NORMALISE_2, ROUND, PACK, PUT_Z
  } state_t;

  localparam logic [31:0] QNAN = 32'hFFC00000;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d, z_q, z_d;
  logic [23:0]        a_m_q, a_m_d, b_m_q, b_m_d, z_m_q, z_m_d;
  logic signed [9:0]  a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
  logic               a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
  logic               guard_q, guard_d, round_bit_q, round_bit_d, sticky_q, sticky_d;
  logic [26:0]        quotient_q, quotient_d;
  logic [23:0]        remainder_q, remainder_d, divisor_q, divisor_d;
  logic [49:0]        dividend_q, dividend_d;
  logic [4:0]         count_q, count_d;
  logic               input_a_ack_q, input_a_ack_d, input_b_ack_q, input_b_ack_d;
  logic [31:0]        output_z_q, output_z_d;
  logic               output_z_stb_q, output_z_stb_d, z_loaded_q, z_loaded_d;

  logic a_nan_s, a_inf_s, a_zero_s, b_nan_s, b_inf_s, b_zero_s;
  logic [24:0] trial_s, diff_s;
  logic        trial_ge_s;
  logic [7:0]  pack_exp_s;

  assign a_nan_s  = (a_e_q == 10'sd128) && (a_m_q != 24'd0);
  assign a_inf_s  = (a_e_q == 10'sd128) && (a_m_q == 24'd0);
  assign a_zero_s = (a_e_q == -10'sd127) && (a_m_q == 24'd0);
  assign b_nan_s  = (b_e_q == 10'sd128) && (b_m_q != 24'd0);
  assign b_inf_s  = (b_e_q == 10'sd128) && (b_m_q == 24'd0);
  assign b_zero_s = (b_e_q == -10'sd127) && (b_m_q == 24'd0);

  // The top 23 dividend bits are below any normalised divisor, so the first
  // step takes all 24 mantissa bits at once; the remaining 26 steps shift in
  // one bit each, giving 27 quotient bits in 27 cycles.
  assign trial_s    = (count_q == 5'd0) ? {1'b0, dividend_q[49:26]}
                                        : {remainder_q, dividend_q[49]};
  assign diff_s     = trial_s - {1'b0, divisor_q};
  assign trial_ge_s = (trial_s >= {1'b0, divisor_q});
  assign pack_exp_s = z_e_q[7:0] + 8'd127;

  // Next-state and datapath update for every stage of the operation.
  always_comb begin
    state_d = state_q;  a_d = a_q;  b_d = b_q;  z_d = z_q;
    a_m_d = a_m_q;  b_m_d = b_m_q;  z_m_d = z_m_q;
    a_e_d = a_e_q;  b_e_d = b_e_q;  z_e_d = z_e_q;
    a_s_d = a_s_q;  b_s_d = b_s_q;  z_s_d = z_s_q;
    guard_d = guard_q;  round_bit_d = round_bit_q;  sticky_d = sticky_q;
    quotient_d = quotient_q;  remainder_d = remainder_q;
    divisor_d = divisor_q;  dividend_d = dividend_q;  count_d = count_q;
    input_a_ack_d = input_a_ack_q;  input_b_ack_d = input_b_ack_q;
    output_z_d = output_z_q;  output_z_stb_d = output_z_stb_q;  z_loaded_d = z_loaded_q;
    case (state_q)
      GET_A: begin
        input_a_ack_d = 1'b1;
        if (input_a_ack_q && input_a_stb) begin
          a_d = input_a;  input_a_ack_d = 1'b0;  state_d = GET_B;
        end else begin
          state_d = GET_A;
        end
      end
      GET_B: begin
        input_b_ack_d = 1'b1;
        if (input_b_ack_q && input_b_stb) begin
          b_d = input_b;  input_b_ack_d = 1'b0;  state_d = UNPACK;
        end else begin
          state_d = GET_B;
        end
      end
      UNPACK: begin
        a_m_d = {1'b0, a_q[22:0]};
        b_m_d = {1'b0, b_q[22:0]};
        a_e_d = $signed({2'b00, a_q[30:23]}) - 10'sd127;
        b_e_d = $signed({2'b00, b_q[30:23]}) - 10'sd127;
        a_s_d = a_q[31];
        b_s_d = b_q[31];
        state_d = SPECIAL_CASES;
      end
      SPECIAL_CASES: begin
        state_d = PUT_Z;
        if (a_nan_s || b_nan_s) begin
          z_d = QNAN;
        end else if (a_inf_s && b_inf_s) begin
          z_d = QNAN;
        end else if (a_inf_s) begin
          z_d = {a_s_q ^ b_s_q, 8'hFF, 23'd0};
        end else if (b_inf_s) begin
          z_d = {a_s_q ^ b_s_q, 31'd0};
        end else if (b_zero_s) begin
          z_d = a_zero_s ? QNAN : {a_s_q ^ b_s_q, 8'hFF, 23'd0};
        end else if (a_zero_s) begin
          z_d = {a_s_q ^ b_s_q, 31'd0};
        end else begin
          // Denormals keep the minimum exponent; normals regain the hidden bit.
          if (a_e_q == -10'sd127) a_e_d = -10'sd126;
          else                    a_m_d[23] = 1'b1;
          if (b_e_q == -10'sd127) b_e_d = -10'sd126;
          else                    b_m_d[23] = 1'b1;
          state_d = NORMALISE_A;
        end
      end
      NORMALISE_A: begin
        if (a_m_q[23]) begin
          state_d = NORMALISE_B;
        end else begin
          a_m_d = {a_m_q[22:0], 1'b0};  a_e_d = a_e_q - 10'sd1;
        end
      end
      NORMALISE_B: begin
        if (b_m_q[23]) begin
          state_d = DIVIDE_0;
        end else begin
          b_m_d = {b_m_q[22:0], 1'b0};  b_e_d = b_e_q - 10'sd1;
        end
      end
      DIVIDE_0: begin
        z_s_d = a_s_q ^ b_s_q;
        z_e_d = a_e_q - b_e_q;
        dividend_d = {a_m_q, 26'd0};
        divisor_d = b_m_q;
        quotient_d = 27'd0;
        remainder_d = 24'd0;
        count_d = 5'd0;
        state_d = DIVIDE_1;
      end
      DIVIDE_1: begin
        quotient_d  = {quotient_q[25:0], trial_ge_s};
        remainder_d = trial_ge_s ? diff_s[23:0] : trial_s[23:0];
        dividend_d  = (count_q == 5'd0) ? {dividend_q[25:0], 24'd0}
                                        : {dividend_q[48:0], 1'b0};
        count_d = count_q + 5'd1;
        state_d = (count_q == 5'd26) ? DIVIDE_2 : DIVIDE_1;
      end
      DIVIDE_2: begin
        z_m_d = quotient_q[26:3];
        guard_d = quotient_q[2];
        round_bit_d = quotient_q[1];
        sticky_d = quotient_q[0] | (remainder_q != 24'd0);
        state_d = NORMALISE_1;
      end
      NORMALISE_1: begin
        if (!z_m_q[23]) begin
          z_m_d = {z_m_q[22:0], guard_q};
          guard_d = round_bit_q;
          round_bit_d = 1'b0;
          z_e_d = z_e_q - 10'sd1;
        end else begin
          state_d = NORMALISE_2;
        end
      end
      NORMALISE_2: begin
        // Denormalise towards the minimum exponent, keeping lost bits sticky.
        if (z_e_q < -10'sd126) begin
          z_m_d = {1'b0, z_m_q[23:1]};
          guard_d = z_m_q[0];
          round_bit_d = guard_q;
          sticky_d = sticky_q | round_bit_q;
          z_e_d = z_e_q + 10'sd1;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (guard_q && (round_bit_q | sticky_q | z_m_q[0])) begin
          z_m_d = z_m_q + 24'd1;
          if (z_m_q == 24'hFFFFFF) z_e_d = z_e_q + 10'sd1;
          else                     z_e_d = z_e_q;
        end else begin
          z_m_d = z_m_q;
        end
        state_d = PACK;
      end
      PACK: begin
        z_d = {z_s_q, pack_exp_s, z_m_q[22:0]};
        if (z_e_q == -10'sd126 && !z_m_q[23]) z_d[30:23] = 8'd0;
        else                                  z_d[30:23] = pack_exp_s;
        if (z_e_q > 10'sd127) z_d = {z_s_q, 8'hFF, 23'd0};
        else                  z_d[31] = z_s_q;
        state_d = PUT_Z;
      end
      PUT_Z: begin
        // output_z is loaded one cycle before stb rises and then held.
        if (!output_z_stb_q) begin
          if (z_loaded_q) begin
            output_z_stb_d = 1'b1;
          end else begin
            output_z_d = z_q;  z_loaded_d = 1'b1;
          end
        end else if (output_z_ack) begin
          output_z_stb_d = 1'b0;  z_loaded_d = 1'b0;  state_d = GET_A;
        end else begin
          output_z_stb_d = 1'b1;
        end
      end
      default: begin
        state_d = GET_A;
      end
    endcase
  end

  // State, datapath and handshake registers; reset discards any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GET_A;  a_q <= 32'd0;  b_q <= 32'd0;  z_q <= 32'd0;
      a_m_q <= 24'd0;  b_m_q <= 24'd0;  z_m_q <= 24'd0;
      a_e_q <= 10'sd0;  b_e_q <= 10'sd0;  z_e_q <= 10'sd0;
      a_s_q <= 1'b0;  b_s_q <= 1'b0;  z_s_q <= 1'b0;
      guard_q <= 1'b0;  round_bit_q <= 1'b0;  sticky_q <= 1'b0;
      quotient_q <= 27'd0;  remainder_q <= 24'd0;  divisor_q <= 24'd0;
      dividend_q <= 50'd0;  count_q <= 5'd0;
      input_a_ack_q <= 1'b0;  input_b_ack_q <= 1'b0;
      output_z_q <= 32'd0;  output_z_stb_q <= 1'b0;  z_loaded_q <= 1'b0;
    end else begin
      state_q <= state_d;  a_q <= a_d;  b_q <= b_d;  z_q <= z_d;
      a_m_q <= a_m_d;  b_m_q <= b_m_d;  z_m_q <= z_m_d;
      a_e_q <= a_e_d;  b_e_q <= b_e_d;  z_e_q <= z_e_d;
      a_s_q <= a_s_d;  b_s_q <= b_s_d;  z_s_q <= z_s_d;
      guard_q <= guard_d;  round_bit_q <= round_bit_d;  sticky_q <= sticky_d;
      quotient_q <= quotient_d;  remainder_q <= remainder_d;  divisor_q <= divisor_d;
      dividend_q <= dividend_d;  count_q <= count_d;
      input_a_ack_q <= input_a_ack_d;  input_b_ack_q <= input_b_ack_d;
      output_z_q <= output_z_d;  output_z_stb_q <= output_z_stb_d;  z_loaded_q <= z_loaded_d;
    end
  end

  assign input_a_ack  = input_a_ack_q;
  assign input_b_ack  = input_b_ack_q;
  assign output_z     = output_z_q;
  assign output_z_stb = output_z_stb_q;

endmodule
